slant_raster_scheduler: RTL

- Sequences the four-lane slant receive buffer readout toward HDMI.
- Generates a divide-by-CLK_DIV pixel enable, horizontal and vertical raster counters, sync/DE strobes, and a read-enable strobe that leads DE by a fixed number of pixel slots to cover datapath latency.
- Arbitrates display-bank swaps: a swap happens only when all four receive lanes have completed a frame since the previous vertical sync; otherwise it records a dropped frame.

---
 rtl/slant_raster_scheduler_if.sv | 29 ++
 rtl/slant_raster_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/slant_raster_scheduler_if.sv
// Control/status bundle between the slant receive buffer sequencer and its raster scheduler.
// The slave side is the scheduler; the master side drives run and the per-lane frame events.
interface slant_raster_scheduler_if;
  logic       run;
  logic [3:0] lane_frame_evt;
  logic       pix_en;
  logic       hsync;
  logic       vsync;
  logic       vde;
  logic       mem_read;
  logic       hv_valid;
  logic       frame_start;
  logic       disp_bank;
  logic       swap;
  logic [7:0] drop_cnt;
  logic       busy;

  modport master (
    output run, lane_frame_evt,
    input  pix_en, hsync, vsync, vde, mem_read, hv_valid, frame_start,
           disp_bank, swap, drop_cnt, busy
  );

  modport slave (
    input  run, lane_frame_evt,
    output pix_en, hsync, vsync, vde, mem_read, hv_valid, frame_start,
           disp_bank, swap, drop_cnt, busy
  );
endinterface

// File: rtl/slant_raster_scheduler.sv
// HDMI raster timing, prefetch read strobe and display-bank swap arbitration for the slant buffer.
// Every output is a register; raster state only moves on pix_en clks.
module slant_raster_scheduler #(
  parameter int CLK_DIV   = 5,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int READ_LEAD = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  slant_raster_scheduler_if.slave bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(CLK_DIV);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_DECIDE = VW'(V_ACTIVE + V_FP);

  // Thresholds carry one extra bit so an end bound equal to the total still fits.
  localparam logic [HW:0] H_TOT_X  = (HW+1)'(H_TOTAL);
  localparam logic [HW:0] H_ACT_X  = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0] HS_BEG_X = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0] HS_END_X = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW:0] LEAD_X   = (HW+1)'(READ_LEAD);
  localparam logic [VW:0] V_ACT_X  = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0] VS_BEG_X = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0] VS_END_X = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div_q;
  logic          pix_en_q;
  logic [HW-1:0] hcnt, h_adv, h_nxt, h_look;
  logic [VW-1:0] vcnt, v_adv, v_nxt, v_look;
  logic          h_last, v_last;
  logic [HW:0]   h_ext, h_sum;
  logic [VW:0]   v_ext, v_look_ext;
  logic          active, vde_d, hsync_d, vsync_d, mem_read_d, frame_start_d;
  logic          decide;
  logic [3:0]    sticky;

  logic hsync_q, vsync_q, vde_q, mem_read_q, hv_valid_q, frame_start_q, busy_q;
  logic bank_q, swap_q;
  logic [7:0] drop_q;

  // Free-running pixel divider; pix_en_q is the slot tick for all raster state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q    <= '0;
      pix_en_q <= 1'b0;
    end else begin
      div_q    <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      pix_en_q <= (div_q == DIV_LAST);
    end
  end

  always_comb begin
    h_last = (hcnt == H_LAST);
    v_last = (vcnt == V_LAST);
    h_adv  = h_last ? '0 : hcnt + 1'b1;
    v_adv  = !h_last ? vcnt : (v_last ? '0 : vcnt + 1'b1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      hcnt  <= '0;
      vcnt  <= '0;
    end else if (pix_en_q) begin
      state <= state_nxt;
      hcnt  <= h_nxt;
      vcnt  <= v_nxt;
    end
  end

  // Starting on the last blanking line lets the first frame's line-0 prefetch happen.
  always_comb begin
    state_nxt = state;
    h_nxt     = h_adv;
    v_nxt     = v_adv;
    unique case (state)
      IDLE: begin
        if (bus.run) begin
          state_nxt = RUN;
          h_nxt     = '0;
          v_nxt     = V_LAST;
        end else begin
          h_nxt = '0;
          v_nxt = '0;
        end
      end
      RUN: begin
        if (!bus.run) state_nxt = STOP_PEND;
      end
      STOP_PEND: begin
        if (bus.run) begin
          state_nxt = RUN;
        end else if (h_last && v_last) begin
          state_nxt = IDLE;
          h_nxt     = '0;
          v_nxt     = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        h_nxt     = '0;
        v_nxt     = '0;
      end
    endcase
  end

  // Decode the slot being entered so the registered outputs line up with it.
  always_comb begin
    active = (state_nxt != IDLE);
    h_ext  = {1'b0, h_nxt};
    v_ext  = {1'b0, v_nxt};
    h_sum  = h_ext + LEAD_X;
    if (h_sum >= H_TOT_X) begin
      h_look = HW'(h_sum - H_TOT_X);
      v_look = (v_nxt == V_LAST) ? '0 : v_nxt + 1'b1;
    end else begin
      h_look = HW'(h_sum);
      v_look = v_nxt;
    end
    v_look_ext    = {1'b0, v_look};
    vde_d         = active && (h_ext < H_ACT_X) && (v_ext < V_ACT_X);
    hsync_d       = active && (h_ext >= HS_BEG_X) && (h_ext < HS_END_X);
    vsync_d       = active && (v_ext >= VS_BEG_X) && (v_ext < VS_END_X);
    mem_read_d    = active && ({1'b0, h_look} < H_ACT_X) && (v_look_ext < V_ACT_X);
    frame_start_d = active && (h_nxt == '0) && (v_nxt == '0);
    decide        = pix_en_q && active && (h_nxt == '0) && (v_nxt == V_DECIDE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      vde_q         <= 1'b0;
      mem_read_q    <= 1'b0;
      hv_valid_q    <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else if (pix_en_q) begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      vde_q         <= vde_d;
      mem_read_q    <= mem_read_d;
      hv_valid_q    <= active && !vsync_d;
      frame_start_q <= frame_start_d;
      busy_q        <= active;
    end
  end

  // Decision uses only events seen before this clk; a same-clk event lands in the new window.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sticky <= '0;
      bank_q <= 1'b0;
      swap_q <= 1'b0;
      drop_q <= '0;
    end else begin
      sticky <= (decide ? 4'b0000 : sticky) | bus.lane_frame_evt;
      swap_q <= 1'b0;
      if (decide) begin
        if (&sticky) begin
          bank_q <= ~bank_q;
          swap_q <= 1'b1;
        end else if (drop_q != 8'hFF) begin
          drop_q <= drop_q + 1'b1;
        end
      end
    end
  end

  assign bus.pix_en      = pix_en_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.vde         = vde_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.hv_valid    = hv_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.disp_bank   = bank_q;
  assign bus.swap        = swap_q;
  assign bus.drop_cnt    = drop_q;
  assign bus.busy        = busy_q;

endmodule
